uart_wb_master: RTL and testbench

UART_WB_MASTER -- requirements
Module: uart_wb_master

---
 rtl/uart_wb_pkg.sv | 21 ++
 rtl/uart_wb_resp_ser.sv | 61 ++++++
 rtl/uart_wb_master.sv | 198 +++++++++++++++++++
 tb/tb_uart_wb_master.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_wb_pkg.sv
// uart_wb_pkg
//   Shared constants and types for the UART-to-Wishbone bridge.
//   - CMD_WRITE / CMD_READ : frame command bytes
//   - RSP_ACK / RSP_NAK    : single-byte responses (write done / timeout)
//   - state_e              : bridge FSM state encoding
package uart_wb_pkg;

  localparam logic [7:0] CMD_WRITE = 8'hA5;
  localparam logic [7:0] CMD_READ  = 8'h5A;
  localparam logic [7:0] RSP_ACK   = 8'h06;
  localparam logic [7:0] RSP_NAK   = 8'h15;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
    ST_WB   = 3'd3,
    ST_RESP = 3'd4
  } state_e;

endpackage

// File: rtl/uart_wb_resp_ser.sv
// uart_wb_resp_ser
//   Response serializer: holds up to four response bytes and offers them
//   MSB first on a valid/ready byte stream.
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   load_i             load a new response (ignored bytes beyond load_len_i)
//   load_data_i[31:0]  response bytes, first byte in [31:24]
//   load_len_i[2:0]    number of bytes to send (1..4)
//   tx_valid_o/tx_data_o/tx_ready_i  byte stream towards the UART transmitter
//   done_o             high in the cycle the last byte transfers
// Handshake: a byte transfers on a clock edge where tx_valid_o and tx_ready_i
// are both high; tx_valid_o/tx_data_o never change while waiting for ready.
module uart_wb_resp_ser (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic [31:0] load_data_i,
  input  logic [2:0]  load_len_i,
  output logic        tx_valid_o,
  output logic [7:0]  tx_data_o,
  input  logic        tx_ready_i,
  output logic        done_o
);

  logic [31:0] sr_q, sr_d;
  logic [2:0]  left_q, left_d;
  logic        valid_q, valid_d;

  always_comb begin
    sr_d    = sr_q;
    left_d  = left_q;
    valid_d = valid_q;
    if (load_i) begin
      sr_d    = load_data_i;
      left_d  = load_len_i;
      valid_d = (load_len_i != 3'd0);
    end else if (valid_q && tx_ready_i) begin
      // Shift the next byte into the output slot so it is offered next cycle.
      sr_d   = {sr_q[23:0], 8'h00};
      left_d = left_q - 3'd1;
      if (left_q == 3'd1) valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_q    <= '0;
      left_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      left_q  <= left_d;
      valid_q <= valid_d;
    end
  end

  assign tx_valid_o = valid_q;
  assign tx_data_o  = sr_q[31:24];
  assign done_o     = valid_q && tx_ready_i && (left_q == 3'd1);

endmodule

// File: rtl/uart_wb_master.sv
// uart_wb_master
//   Bridges a UART byte stream to a Wishbone master port.
//   Frame: command (A5 write / 5A read), 4 address bytes MSB first, then for
//   writes 4 data bytes MSB first. Write answers 06, read answers 4 data bytes
//   MSB first. Other bytes seen while idle are dropped.
// Parameters:
//   TIMEOUT_CYCLES  ack wait limit in clk cycles (used only with the macro)
// Build option:
//   UART_WB_TIMEOUT_EN  when defined, a cycle without ack for TIMEOUT_CYCLES
//                       is abandoned and answered with 15.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   rx_valid, rx_data          received byte pulse and value
//   tx_valid, tx_data, tx_ready response byte stream (valid/ready)
//   wbm_*                      Wishbone master signals
//   rx_overrun                 one-cycle pulse when a byte arrives while busy
//   dbg_state_o                current FSM state
module uart_wb_master
  import uart_wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  output logic        rx_overrun,
  output logic [2:0]  dbg_state_o
);

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic        cyc_q, cyc_d;
  logic        stb_q, stb_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic        ovr_q, ovr_d;

  logic        load;
  logic [31:0] load_data;
  logic [2:0]  load_len;
  logic        tx_done;
  logic        timeout;

`ifdef UART_WB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] to_cnt_q;

  // Counts cycles spent in WB; cleared whenever the FSM is elsewhere.
  always_ff @(posedge clk) begin
    if (!rst_n)                to_cnt_q <= '0;
    else if (state_q == ST_WB) to_cnt_q <= to_cnt_q + TW'(1);
    else                       to_cnt_q <= '0;
  end

  assign timeout = (state_q == ST_WB) && (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    cyc_d     = cyc_q;
    stb_d     = stb_q;
    sel_d     = sel_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    ovr_d     = rx_valid && (state_q == ST_WB || state_q == ST_RESP);
    load      = 1'b0;
    load_data = '0;
    load_len  = 3'd0;

    case (state_q)
      ST_IDLE: begin
        if (rx_valid && (rx_data == CMD_WRITE || rx_data == CMD_READ)) begin
          we_d    = (rx_data == CMD_WRITE);
          cnt_d   = 2'd0;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (rx_valid) begin
          adr_d = {adr_q[23:0], rx_data};
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            if (we_q) begin
              state_d = ST_DATA;
            end else begin
              // Strobe is registered on entry so it appears one cycle after
              // the final frame byte.
              state_d = ST_WB;
              cyc_d   = 1'b1;
              stb_d   = 1'b1;
              sel_d   = 4'hF;
            end
          end
        end
      end
      ST_DATA: begin
        if (rx_valid) begin
          dat_d = {dat_q[23:0], rx_data};
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = ST_WB;
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
            sel_d   = 4'hF;
          end
        end
      end
      ST_WB: begin
        // Ack wins over a timeout landing in the same cycle.
        if (wbm_ack_i) begin
          cyc_d     = 1'b0;
          stb_d     = 1'b0;
          sel_d     = 4'h0;
          load      = 1'b1;
          load_data = we_q ? {RSP_ACK, 24'h0} : wbm_dat_i;
          load_len  = we_q ? 3'd1 : 3'd4;
          state_d   = ST_RESP;
        end else if (timeout) begin
          cyc_d     = 1'b0;
          stb_d     = 1'b0;
          sel_d     = 4'h0;
          load      = 1'b1;
          load_data = {RSP_NAK, 24'h0};
          load_len  = 3'd1;
          state_d   = ST_RESP;
        end
      end
      ST_RESP: begin
        if (tx_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      sel_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      ovr_q   <= ovr_d;
    end
  end

  uart_wb_resp_ser u_resp_ser (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (load),
    .load_data_i (load_data),
    .load_len_i  (load_len),
    .tx_valid_o  (tx_valid),
    .tx_data_o   (tx_data),
    .tx_ready_i  (tx_ready),
    .done_o      (tx_done)
  );

  assign wbm_cyc_o   = cyc_q;
  assign wbm_stb_o   = stb_q;
  assign wbm_we_o    = we_q;
  assign wbm_sel_o   = sel_q;
  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = dat_q;
  assign rx_overrun  = ovr_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_wb_master.sv
// tb_uart_wb_master
//   Directed bench for uart_wb_master with a Wishbone slave model, a
//   Wishbone transaction scoreboard and a response-byte scoreboard.
//   Inputs change 1 time unit after the rising edge; monitors sample on the
//   falling edge.
module tb_uart_wb_master;
  import uart_wb_pkg::*;

  localparam int TO_CYC = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;
  logic        rx_overrun;
  logic [2:0]  dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  // Scoreboards: {we, sel, adr, dat} per Wishbone cycle, and response bytes.
  logic [68:0] exp_wb_q[$];
  logic [7:0]  exp_tx_q[$];

  // Slave model controls.
  logic        ack_en;
  int          ack_delay;
  logic [31:0] rd_value;
  int          stb_cycles = 0;
  int          wb_count = 0;

  always #5 clk = ~clk;

  uart_wb_master #(.TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .wbm_cyc_o   (wbm_cyc_o),
    .wbm_stb_o   (wbm_stb_o),
    .wbm_we_o    (wbm_we_o),
    .wbm_sel_o   (wbm_sel_o),
    .wbm_adr_o   (wbm_adr_o),
    .wbm_dat_o   (wbm_dat_o),
    .wbm_dat_i   (wbm_dat_i),
    .wbm_ack_i   (wbm_ack_i),
    .rx_overrun  (rx_overrun),
    .dbg_state_o (dbg_state)
  );

  task automatic check(input string tag, input logic [68:0] got, input logic [68:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Wishbone slave: checks each new cycle against the scoreboard and acks
  // after ack_delay strobe cycles when enabled.
  always @(negedge clk) begin
    if (wbm_ack_i) begin
      wbm_ack_i = 1'b0;
    end else if (wbm_cyc_o && wbm_stb_o) begin
      if (stb_cycles == 0) begin
        wb_count++;
        if (exp_wb_q.size() == 0) begin
          check("wb_unexpected", {wbm_we_o, wbm_sel_o, wbm_adr_o}, 37'h0);
        end else begin
          check("wb_txn", {wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_we_o ? wbm_dat_o : 32'h0},
                exp_wb_q.pop_front());
        end
      end
      stb_cycles++;
      if (ack_en && stb_cycles >= ack_delay) begin
        wbm_ack_i  = 1'b1;
        wbm_dat_i  = rd_value;
        stb_cycles = 0;
      end
    end else begin
      stb_cycles = 0;
    end
  end

  // Response monitor: every transferred byte must match the next expected one.
  always @(negedge clk) begin
    if (rst_n && tx_valid && tx_ready) begin
      if (exp_tx_q.size() == 0) check("tx_unexpected", tx_data, 69'h1FF);
      else                      check("tx_byte", tx_data, exp_tx_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while ((exp_tx_q.size() != 0 || tx_valid) && n < 300) begin
      tick();
      n++;
    end
    check({tag, "_drain"}, exp_tx_q.size(), 0);
    tick();
    check({tag, "_idle"}, dbg_state, ST_IDLE);
  endtask

  initial begin
    int base;
    int n;
    rst_n     = 1'b0;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    tx_ready  = 1'b1;
    wbm_ack_i = 1'b0;
    wbm_dat_i = 32'h0;
    ack_en    = 1'b1;
    ack_delay = 1;
    rd_value  = 32'h0;

    // Reset values.
    repeat (3) tick();
    check("rst_cyc", wbm_cyc_o, 0);
    check("rst_stb", wbm_stb_o, 0);
    check("rst_we", wbm_we_o, 0);
    check("rst_sel", wbm_sel_o, 0);
    check("rst_adr", wbm_adr_o, 0);
    check("rst_dat", wbm_dat_o, 0);
    check("rst_txv", tx_valid, 0);
    check("rst_txd", tx_data, 0);
    check("rst_ovr", rx_overrun, 0);
    check("rst_state", dbg_state, ST_IDLE);
    rst_n = 1'b1;
    tick();

    // Write, ack after 3 cycles.
    ack_delay = 3;
    exp_wb_q.push_back({1'b1, 4'hF, 32'h3000_0004, 32'hDEAD_BEEF});
    exp_tx_q.push_back(8'h06);
    send_byte(8'hA5);
    send_word(32'h3000_0004);
    send_word(32'hDEAD_BEEF);
    check("wr_stb_lat", wbm_stb_o, 1);
    wait_done("wr");
    check("wr_count", wb_count, 1);

    // Read with tx_ready stalled 5 cycles before byte 2.
    ack_delay = 2;
    rd_value  = 32'h1234_5678;
    tx_ready  = 1'b0;
    exp_wb_q.push_back({1'b0, 4'hF, 32'h3000_0010, 32'h0});
    exp_tx_q.push_back(8'h12);
    exp_tx_q.push_back(8'h34);
    exp_tx_q.push_back(8'h56);
    exp_tx_q.push_back(8'h78);
    send_byte(8'h5A);
    send_word(32'h3000_0010);
    check("rd_stb_lat", wbm_stb_o, 1);
    n = 0;
    while (!tx_valid && n < 50) begin
      tick();
      n++;
    end
    check("rd_first_valid", tx_valid, 1);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    repeat (5) tick();
    check("rd_stall_valid", tx_valid, 1);
    check("rd_stall_data", tx_data, 8'h34);
    tx_ready = 1'b1;
    wait_done("rd");

    // Garbage bytes before a read.
    base     = wb_count;
    ack_delay = 1;
    rd_value = 32'hCAFE_F00D;
    exp_wb_q.push_back({1'b0, 4'hF, 32'h3000_0000, 32'h0});
    exp_tx_q.push_back(8'hCA);
    exp_tx_q.push_back(8'hFE);
    exp_tx_q.push_back(8'hF0);
    exp_tx_q.push_back(8'h0D);
    send_byte(8'h00);
    send_byte(8'hFF);
    check("gb_idle", dbg_state, ST_IDLE);
    send_byte(8'h5A);
    send_word(32'h3000_0000);
    wait_done("gb");
    check("gb_count", wb_count, base + 1);

    // Missing ack.
    ack_en   = 1'b0;
    rd_value = 32'h0102_0304;
    exp_wb_q.push_back({1'b0, 4'hF, 32'h4000_0000, 32'h0});
    send_byte(8'h5A);
    send_word(32'h4000_0000);
`ifdef UART_WB_TIMEOUT_EN
    exp_tx_q.push_back(8'h15);
    n = 0;
    while (wbm_cyc_o && n < 100) begin
      tick();
      n++;
    end
    check("to_cyc_len", n, TO_CYC);
    wait_done("to");
    ack_en = 1'b1;
`else
    repeat (40) tick();
    check("noto_cyc_held", wbm_cyc_o, 1);
    check("noto_no_tx", tx_valid, 0);
    exp_tx_q.push_back(8'h01);
    exp_tx_q.push_back(8'h02);
    exp_tx_q.push_back(8'h03);
    exp_tx_q.push_back(8'h04);
    ack_en = 1'b1;
    wait_done("noto");
`endif

    // Byte arriving during the Wishbone cycle.
    ack_delay = 6;
    exp_wb_q.push_back({1'b1, 4'hF, 32'h0000_0100, 32'h1122_3344});
    exp_tx_q.push_back(8'h06);
    send_byte(8'hA5);
    send_word(32'h0000_0100);
    send_word(32'h1122_3344);
    send_byte(8'h5A);
    check("ovr_pulse", rx_overrun, 1);
    tick();
    check("ovr_clear", rx_overrun, 0);
    wait_done("ovr");

    // Reset in the middle of the address field, then a normal read.
    ack_delay = 1;
    send_byte(8'h5A);
    send_byte(8'h30);
    send_byte(8'h00);
    rst_n = 1'b0;
    tick();
    tick();
    check("mid_rst_state", dbg_state, ST_IDLE);
    check("mid_rst_cyc", wbm_cyc_o, 0);
    rst_n    = 1'b1;
    rd_value = 32'h0BAD_F00D;
    base     = wb_count;
    exp_wb_q.push_back({1'b0, 4'hF, 32'h0000_0200, 32'h0});
    exp_tx_q.push_back(8'h0B);
    exp_tx_q.push_back(8'hAD);
    exp_tx_q.push_back(8'hF0);
    exp_tx_q.push_back(8'h0D);
    send_byte(8'h5A);
    send_word(32'h0000_0200);
    check("post_rst_stb", wbm_stb_o, 1);
    wait_done("post_rst");
    check("post_rst_count", wb_count, base + 1);
    check("wb_sb_empty", exp_wb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
